// File: rtl/seq_priority_encoder_if.sv
// Request-capture and index-report bundle for seq_priority_encoder; master is the encoder side.
// Carries no logic, so it adds no latency.
// Backpressure: out_ready from the consumer stalls idx/out_valid.
interface seq_priority_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         load;
  logic [W-1:0] idx;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         none;

  modport master (
    input  req_in, load, out_ready,
    output idx, out_valid, busy, done, none
  );

  modport slave (
    output req_in, load, out_ready,
    input  idx, out_valid, busy, done, none
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Captures an N-bit request vector and reports each set index, MSB first (LSB first with SPE_LSB_PRIORITY_EN).
// Latency: first idx valid the cycle after an accepted load; then one index per handshake cycle.
// Backpressure: out_ready low holds idx/pend/out_valid; load is ignored while busy.
module seq_priority_encoder #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_priority_encoder_if.master bus
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] idx_q, idx_d;
  logic         out_valid_q, out_valid_d;
  logic         done_q, done_d;
  logic         none_q, none_d;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pend_nxt;

  function automatic logic [W-1:0] prio_idx(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
`ifdef SPE_LSB_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
`endif
    return r;
  endfunction

  always_comb begin
    clr_mask        = '0;
    clr_mask[idx_q] = 1'b1;
    pend_nxt        = pend_q & ~clr_mask;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    none_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.req_in != '0) begin
            pend_d      = bus.req_in;
            idx_d       = prio_idx(bus.req_in);
            out_valid_d = 1'b1;
            state_d     = SCAN;
          end else begin
            done_d = 1'b1;
            none_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_valid_q && bus.out_ready) begin
          pend_d = pend_nxt;
          if (pend_nxt != '0) begin
            idx_d = prio_idx(pend_nxt);
          end else begin
            // idx keeps the last reported value once the scan drains.
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      none_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      none_q      <= none_d;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = done_q;
  assign bus.none      = none_q;
endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench: stimulus pushes expected indices/done events; a negedge monitor pops and compares.
module tb_seq_priority_encoder;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    bit is_done;
    int val;
  } exp_t;

  exp_t sb[$];

  seq_priority_encoder_if #(.N(N)) bus ();

  seq_priority_encoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SPE_LSB_PRIORITY_EN
  localparam int ORD0 = 2, ORD1 = 5, ORD2 = 7;
`else
  localparam int ORD0 = 7, ORD1 = 5, ORD2 = 2;
`endif

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idx(input int v);
    exp_t e;
    e.is_done = 1'b0;
    e.val     = v;
    sb.push_back(e);
  endtask

  task automatic push_done(input int nn);
    exp_t e;
    e.is_done = 1'b1;
    e.val     = nn;
    sb.push_back(e);
  endtask

  task automatic push_a4();
    push_idx(ORD0);
    push_idx(ORD1);
    push_idx(ORD2);
    push_done(0);
  endtask

  // Bounded wait for the done pulse; counts as a failure on timeout.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_done_seen"}, bus.done, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_idx act=%0d exp=empty", bus.idx);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_idx", 0, e.is_done);
          chk("sb_idx", bus.idx, e.val);
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done act=1 exp=empty");
        end else begin
          e = sb.pop_front();
          chk("sb_kind_done", 1, e.is_done);
          chk("sb_none", bus.none, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.req_in    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_idx", bus.idx, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_none", bus.none, 0);
    rst = 1'b0;
    tick();

    // Basic scan, ready held high
    push_a4();
    bus.load   = 1'b1;
    bus.req_in = 8'b1010_0100;
    tick();
    bus.load = 1'b0;
    chk("basic_v0", bus.out_valid, 1);
    chk("basic_i0", bus.idx, ORD0);
    chk("basic_busy", bus.busy, 1);
    tick();
    chk("basic_i1", bus.idx, ORD1);
    tick();
    chk("basic_i2", bus.idx, ORD2);
    chk("basic_v2", bus.out_valid, 1);
    tick();
    chk("basic_done", bus.done, 1);
    chk("basic_done_none", bus.none, 0);
    chk("basic_done_valid", bus.out_valid, 0);
    chk("basic_done_busy", bus.busy, 0);
    tick();
    chk("basic_done_pulse", bus.done, 0);

    // Back-pressure
    push_a4();
    bus.out_ready = 1'b0;
    bus.load      = 1'b1;
    bus.req_in    = 8'b1010_0100;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_idx", bus.idx, ORD0);
      chk("bp_hold_valid", bus.out_valid, 1);
      if (c < 2) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_i1", bus.idx, ORD1);
    wait_done("bp");
    tick();

    // Empty vector
    push_done(1);
    bus.load   = 1'b1;
    bus.req_in = '0;
    tick();
    bus.load = 1'b0;
    chk("empty_done", bus.done, 1);
    chk("empty_none", bus.none, 1);
    chk("empty_valid", bus.out_valid, 0);
    chk("empty_busy", bus.busy, 0);
    tick();
    chk("empty_done_pulse", bus.done, 0);
    chk("empty_none_pulse", bus.none, 0);
    chk("empty_valid2", bus.out_valid, 0);
    chk("empty_busy2", bus.busy, 0);

    // Load held through the scan, then reload in the done cycle
    push_a4();
    push_idx(0);
    push_done(0);
    bus.load   = 1'b1;
    bus.req_in = 8'b1010_0100;
    tick();
    bus.req_in = 8'hFF;
    tick();
    chk("lds_i1", bus.idx, ORD1);
    tick();
    chk("lds_i2", bus.idx, ORD2);
    tick();
    chk("lds_done", bus.done, 1);
    bus.req_in = 8'h01;
    tick();
    bus.load = 1'b0;
    chk("reload_idx", bus.idx, 0);
    chk("reload_valid", bus.out_valid, 1);
    tick();
    chk("reload_done", bus.done, 1);
    tick();

    // Reset mid-scan
    push_idx(ORD0);
    bus.load   = 1'b1;
    bus.req_in = 8'b1010_0100;
    tick();
    bus.load = 1'b0;
    tick();
    chk("mid_i1", bus.idx, ORD1);
    rst = 1'b1;
    tick();
    chk("mid_rst_idx", bus.idx, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_none", bus.none, 0);
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.done || bus.out_valid) seen = 1'b1;
      end
      chk("mid_no_done", seen, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
